// File: rtl/mac_pkg.sv
// ============================================================================
// Module      : mac_pkg
// Description : Shared types and constants for the mac_acc accumulator slice.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mac_pkg;

  typedef enum logic [0:0] {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam int PROD_W = 8;

  // Limits are returned 32 bits wide; callers keep the low w bits.
  function automatic logic [31:0] sat_max(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_add.sv
// ============================================================================
// Module      : sat_add
// Description : Combinational signed ACC_W adder with overflow flag; clamps
//               to the signed limits when MAC_ACC_SAT_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sat_add
  import mac_pkg::*;
#(
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  logic [ACC_W-1:0] w_raw;

  assign w_raw = i_a + i_b;
  assign o_ovf = (i_a[ACC_W-1] == i_b[ACC_W-1]) && (w_raw[ACC_W-1] != i_a[ACC_W-1]);

`ifdef MAC_ACC_SAT_EN
  localparam logic [31:0] c_max32 = sat_max(ACC_W);
  localparam logic [31:0] c_min32 = sat_min(ACC_W);

  // On overflow both operands share a sign, so i_a's sign picks the rail.
  assign o_sum = !o_ovf        ? w_raw :
                 i_a[ACC_W-1]  ? c_min32[ACC_W-1:0] : c_max32[ACC_W-1:0];
`else
  assign o_sum = w_raw;
`endif

endmodule

`default_nettype wire

// File: rtl/mac_acc.sv
// ============================================================================
// Module      : mac_acc
// Description : Signed multiply-accumulate back end summing N products per
//               result. Optional saturation via macro MAC_ACC_SAT_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_acc
  import mac_pkg::*;
#(
  parameter int ACC_W = 10,
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic              out_ovf
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic [ACC_W-1:0] r_out_acc;
  logic             r_out_ovf;

  logic [ACC_W-1:0] w_ext;
  logic [ACC_W-1:0] w_sum;
  logic             w_add_ovf;
  logic             w_accept;
  logic             w_last;

  assign w_ext    = ACC_W'(signed'(in_p));
  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CNT_W'(N - 1));

  sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .i_a   (r_acc),
    .i_b   (w_ext),
    .o_sum (w_sum),
    .o_ovf (w_add_ovf)
  );

  // Handshake outputs depend on the state register only.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid && w_last) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_ACC;
      end
      default: w_state_nxt = ST_ACC;
    endcase
    if (clr) w_state_nxt = ST_ACC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ACC;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_out_acc <= '0;
      r_out_ovf <= 1'b0;
    end else if (clr) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_out_acc <= w_sum;
        r_out_ovf <= r_ovf | w_add_ovf;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_ovf     <= 1'b0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_W'(1);
        r_ovf <= r_ovf | w_add_ovf;
      end
    end
  end

  assign out_acc = r_out_acc;
  assign out_ovf = r_out_ovf;

endmodule

`default_nettype wire

// File: tb/tb_mac_acc.sv
// ============================================================================
// Module      : tb_mac_acc
// Description : Self-checking bench for mac_acc; three instances (default,
//               ACC_W=8, N=1) share stimulus and are checked against a model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mac_acc;

  localparam int WW [3] = '{10, 8, 10};
  localparam int NN [3] = '{4, 4, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_p = 8'd0;
  logic       out_ready = 1'b0;

  logic              rdy [3];
  logic              vld [3];
  logic              ovo [3];
  logic signed [9:0] acc0;
  logic signed [7:0] acc1;
  logic signed [9:0] acc2;
  int                acco [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mac_acc #(.ACC_W(10), .N(4), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_p(in_p), .out_valid(vld[0]), .out_ready(out_ready), .out_acc(acc0), .out_ovf(ovo[0]));
  mac_acc #(.ACC_W(8), .N(4), .CNT_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_p(in_p), .out_valid(vld[1]), .out_ready(out_ready), .out_acc(acc1), .out_ovf(ovo[1]));
  mac_acc #(.ACC_W(10), .N(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy[2]),
    .in_p(in_p), .out_valid(vld[2]), .out_ready(out_ready), .out_acc(acc2), .out_ovf(ovo[2]));

  assign acco[0] = int'(acc0);
  assign acco[1] = int'(acc1);
  assign acco[2] = int'(acc2);

  function automatic void chk(string nm, int k, longint got, longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d t=%0t got=%0d expected=%0d", nm, k, $time, got, exp);
    end
  endfunction

  // Reference model: a result is the ordered fold of the N products taken
  // while the instance was not holding a result.
  int  mq [3][$];
  bit  m_hold [3];
  int  m_oacc [3];
  bit  m_oovf [3];

  function automatic void fold(int k, output int res, output bit ov);
    longint hi = (longint'(1) << (WW[k] - 1)) - 1;
    longint lo = -(longint'(1) << (WW[k] - 1));
    longint m  = longint'(1) << WW[k];
    longint a  = 0;
    longint s;
    ov = 1'b0;
    foreach (mq[k][i]) begin
      s = a + mq[k][i];
      if (s > hi || s < lo) begin
        ov = 1'b1;
`ifdef MAC_ACC_SAT_EN
        s = (s > hi) ? hi : lo;
`else
        s = ((s % m) + m) % m;
        if (s > hi) s = s - m;
`endif
      end
      a = s;
    end
    res = int'(a);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_hold[k] = 1'b0;
        m_oacc[k] = 0;
        m_oovf[k] = 1'b0;
        mq[k].delete();
      end else if (clr) begin
        m_hold[k] = 1'b0;
        mq[k].delete();
      end else if (!m_hold[k]) begin
        if (in_valid) begin
          mq[k].push_back(int'($signed(in_p)));
          if (mq[k].size() == NN[k]) begin
            fold(k, m_oacc[k], m_oovf[k]);
            m_hold[k] = 1'b1;
            mq[k].delete();
          end
        end
      end else if (out_ready) begin
        m_hold[k] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("in_ready", k, longint'(rdy[k]), longint'(!m_hold[k]));
      chk("out_valid", k, longint'(vld[k]), longint'(m_hold[k]));
      chk("out_acc", k, longint'(acco[k]), longint'(m_oacc[k]));
      chk("out_ovf", k, longint'(ovo[k]), longint'(m_oovf[k]));
    end
  end

  // Present p until instance k accepts it; returns just after the accepting edge.
  task automatic put(int k, int p);
    bit r;
    in_valid = 1'b1;
    in_p     = 8'(p);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      r = rdy[k];
      @(posedge clk);
      #1;
      if (r) return;
    end
    chk("put_timeout", k, 0, 1);
  endtask

  task automatic wait_valid(int k);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (vld[k]) return;
    end
    chk("valid_timeout", k, 0, 1);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", k, longint'(rdy[k]), 1);
      chk("rst_valid", k, longint'(vld[k]), 0);
      chk("rst_acc", k, longint'(acco[k]), 0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Back-to-back products, result one cycle after the last accept.
    out_ready = 1'b1;
    put(0, 64); put(0, -56); put(0, 7); put(0, -8);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid", 0, longint'(vld[0]), 1);
    chk("t1_acc", 0, longint'(acco[0]), 7);
    chk("t1_ovf", 0, longint'(ovo[0]), 0);
    chk("t1_bubble", 0, longint'(rdy[0]), 0);
    @(negedge clk);
    chk("t1_ready_back", 0, longint'(rdy[0]), 1);

    // Back-pressure holds the result and stalls input.
    pulse_clr();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_p      = 8'd3;
    wait_valid(0);
    chk("t2_first", 0, longint'(acco[0]), 12);
    repeat (5) begin
      @(negedge clk);
      chk("t2_stable", 0, longint'(acco[0]), 12);
      chk("t2_stall", 0, longint'(rdy[0]), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    wait_valid(0);
    chk("t2_second", 0, longint'(acco[0]), 12);

    // Narrow accumulator overflow.
    pulse_clr();
    in_p = 8'd64;
    wait_valid(1);
`ifdef MAC_ACC_SAT_EN
    chk("t3_acc", 1, longint'(acco[1]), 127);
`else
    chk("t3_acc", 1, longint'(acco[1]), 0);
`endif
    chk("t3_ovf", 1, longint'(ovo[1]), 1);
    in_p = 8'd1;
    wait_valid(1);
    chk("t3_next_acc", 1, longint'(acco[1]), 4);
    chk("t3_next_ovf", 1, longint'(ovo[1]), 0);

    // clr aborts a partial sum and wins over a same-cycle accept.
    pulse_clr();
    put(0, 10); put(0, 20);
    in_valid = 1'b1;
    in_p     = 8'd99;
    pulse_clr();
    put(0, 1); put(0, 1); put(0, 1); put(0, 1);
    in_valid = 1'b0;
    wait_valid(0);
    chk("t4_acc", 0, longint'(acco[0]), 4);

    // Asynchronous reset while a result is held.
    pulse_clr();
    out_ready = 1'b0;
    put(0, 5); put(0, 5); put(0, 5); put(0, 5);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", 0, longint'(vld[0]), 0);
    chk("t5_ready", 0, longint'(rdy[0]), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    put(0, -8); put(0, -8); put(0, -8); put(0, -8);
    in_valid = 1'b0;
    wait_valid(0);
    chk("t5_acc", 0, longint'(acco[0]), -32);

    // N=1 instance: one result per accept, accepts every other cycle.
    pulse_clr();
    put(2, 5);
    @(negedge clk);
    chk("t6_first", 2, longint'(acco[2]), 5);
    chk("t6_first_v", 2, longint'(vld[2]), 1);
    put(2, -3);
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_second", 2, longint'(acco[2]), -3);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      in_p      = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      clr       = ($urandom_range(0, 39) == 0);
    end
    clr      = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
